// File: rtl/axi_ram_slave_if.sv
// AXI4 bus bundle between a master (driver) and the axi_ram_slave memory.
// Carries the five AXI channels:
//   AW: awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid / awready
//   W : wdata, wstrb, wlast, wvalid / wready
//   B : bid, bresp, bvalid / bready
//   AR: arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid / arready
//   R : rid, rdata, rresp, rlast, rvalid / rready
// The master modport drives requests; the slave modport drives ready and responses.
interface axi_ram_slave_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8
);
  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awlock;
  logic [3:0]            awcache;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;

  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;

  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_ram_slave.sv
// AXI4 slave memory: accepts write and read bursts and stores data in a
// byte-strobed word array. Write and read sides are independent FSMs and
// may be busy at the same time; each handles one transaction at a time.
// Ports:
//   clk   - clock, everything on the rising edge
//   reset - synchronous active-high reset (memory contents are kept)
//   bus   - axi_ram_slave_if slave modport (AW, W, B, AR, R channels)
// FIXED and INCR bursts with size up to the bus width are served normally;
// anything else completes its handshakes but returns SLVERR, does not write,
// and reads back zero.
module axi_ram_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8
) (
  input logic           clk,
  input logic           reset,
  axi_ram_slave_if.slave bus
);

  localparam int STRB_SHIFT = $clog2(STRB_WIDTH);
  localparam int WORD_AW    = ADDR_WIDTH - STRB_SHIFT;
  localparam int DEPTH      = 1 << WORD_AW;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // A burst is unsupported when it is WRAP/reserved or wider than the bus.
  function automatic logic burst_bad(input logic [1:0] burst, input logic [2:0] size);
    return burst[1] || (int'(size) > STRB_SHIFT);
  endfunction

  // INCR steps by the beat size and wraps at the top of the address space.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                       input logic [1:0] burst,
                                                       input logic [2:0] size);
    if (burst == 2'b01) return a + (ADDR_WIDTH'(1) << size);
    return a;
  endfunction

  function automatic logic [WORD_AW-1:0] word_of(input logic [ADDR_WIDTH-1:0] a);
    return a[ADDR_WIDTH-1:STRB_SHIFT];
  endfunction

  // Sideband qualifiers are accepted but have no effect on this memory.
  logic unused_sideband;
  assign unused_sideband = ^{bus.awlock, bus.awcache, bus.awprot,
                             bus.arlock, bus.arcache, bus.arprot};

  // ---------------- write side ----------------
  wstate_t               wstate, wstate_n;
  logic [ID_WIDTH-1:0]   wid, wid_n;
  logic [ADDR_WIDTH-1:0] waddr, waddr_n;
  logic [7:0]            wlen, wlen_n, wcnt, wcnt_n;
  logic [2:0]            wsize, wsize_n;
  logic [1:0]            wburst, wburst_n;
  logic                  wbad, wbad_n, werr, werr_n;
  logic                  awready_r, awready_n, wready_r, wready_n, bvalid_r, bvalid_n;
  logic [ID_WIDTH-1:0]   bid_r, bid_n;
  logic [1:0]            bresp_r, bresp_n;
  logic                  mem_we;

  // Next-state and next-output computation for the write side. The burst
  // ends on the beat count alone; wlast disagreeing with the count only
  // poisons the response.
  always_comb begin
    wstate_n  = wstate;
    wid_n     = wid;
    waddr_n   = waddr;
    wlen_n    = wlen;
    wcnt_n    = wcnt;
    wsize_n   = wsize;
    wburst_n  = wburst;
    wbad_n    = wbad;
    werr_n    = werr;
    awready_n = awready_r;
    wready_n  = wready_r;
    bvalid_n  = bvalid_r;
    bid_n     = bid_r;
    bresp_n   = bresp_r;
    mem_we    = 1'b0;
    case (wstate)
      W_IDLE: begin
        awready_n = 1'b1;
        if (bus.awvalid && awready_r) begin
          wid_n     = bus.awid;
          waddr_n   = bus.awaddr;
          wlen_n    = bus.awlen;
          wsize_n   = bus.awsize;
          wburst_n  = bus.awburst;
          wbad_n    = burst_bad(bus.awburst, bus.awsize);
          werr_n    = 1'b0;
          wcnt_n    = 8'd0;
          awready_n = 1'b0;
          wready_n  = 1'b1;
          wstate_n  = W_DATA;
        end
      end
      W_DATA: begin
        if (bus.wvalid && wready_r) begin
          mem_we  = !wbad;
          waddr_n = next_addr(waddr, wburst, wsize);
          wcnt_n  = wcnt + 8'd1;
          if (bus.wlast != (wcnt == wlen)) werr_n = 1'b1;
          if (wcnt == wlen) begin
            wready_n = 1'b0;
            bvalid_n = 1'b1;
            bid_n    = wid;
            bresp_n  = (wbad || werr_n) ? RESP_SLVERR : RESP_OKAY;
            wstate_n = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (bvalid_r && bus.bready) begin
          bvalid_n  = 1'b0;
          awready_n = 1'b1;
          wstate_n  = W_IDLE;
        end
      end
      default: wstate_n = W_IDLE;
    endcase
  end

  // Write-side state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      wstate    <= W_IDLE;
      wid       <= '0;
      waddr     <= '0;
      wlen      <= '0;
      wcnt      <= '0;
      wsize     <= '0;
      wburst    <= '0;
      wbad      <= 1'b0;
      werr      <= 1'b0;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bid_r     <= '0;
      bresp_r   <= '0;
    end else begin
      wstate    <= wstate_n;
      wid       <= wid_n;
      waddr     <= waddr_n;
      wlen      <= wlen_n;
      wcnt      <= wcnt_n;
      wsize     <= wsize_n;
      wburst    <= wburst_n;
      wbad      <= wbad_n;
      werr      <= werr_n;
      awready_r <= awready_n;
      wready_r  <= wready_n;
      bvalid_r  <= bvalid_n;
      bid_r     <= bid_n;
      bresp_r   <= bresp_n;
    end
  end

  // Byte-lane write into the array; memory contents survive reset.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (bus.wstrb[i]) mem[word_of(waddr)][i*8 +: 8] <= bus.wdata[i*8 +: 8];
      end
    end
  end

  assign bus.awready = awready_r;
  assign bus.wready  = wready_r;
  assign bus.bvalid  = bvalid_r;
  assign bus.bid     = bid_r;
  assign bus.bresp   = bresp_r;

  // ---------------- read side ----------------
  rstate_t               rstate, rstate_n;
  logic [ADDR_WIDTH-1:0] raddr, raddr_n;
  logic [7:0]            rlen, rlen_n, rcnt, rcnt_n;
  logic [2:0]            rsize, rsize_n;
  logic [1:0]            rburst, rburst_n;
  logic                  rbad, rbad_n;
  logic                  arready_r, arready_n, rvalid_r, rvalid_n, rlast_r, rlast_n;
  logic [ID_WIDTH-1:0]   rid_r, rid_n;
  logic [DATA_WIDTH-1:0] rdata_r, rdata_n;
  logic [1:0]            rresp_r, rresp_n;

  // Next-state and next-output computation for the read side. Data for the
  // next beat is fetched as the current one is accepted, so a write landing
  // on the same word in that cycle is not yet visible.
  always_comb begin
    rstate_n  = rstate;
    raddr_n   = raddr;
    rlen_n    = rlen;
    rcnt_n    = rcnt;
    rsize_n   = rsize;
    rburst_n  = rburst;
    rbad_n    = rbad;
    arready_n = arready_r;
    rvalid_n  = rvalid_r;
    rlast_n   = rlast_r;
    rid_n     = rid_r;
    rdata_n   = rdata_r;
    rresp_n   = rresp_r;
    case (rstate)
      R_IDLE: begin
        arready_n = 1'b1;
        if (bus.arvalid && arready_r) begin
          raddr_n   = bus.araddr;
          rlen_n    = bus.arlen;
          rcnt_n    = 8'd0;
          rsize_n   = bus.arsize;
          rburst_n  = bus.arburst;
          rbad_n    = burst_bad(bus.arburst, bus.arsize);
          arready_n = 1'b0;
          rid_n     = bus.arid;
          rdata_n   = rbad_n ? '0 : mem[word_of(bus.araddr)];
          rresp_n   = rbad_n ? RESP_SLVERR : RESP_OKAY;
          rvalid_n  = 1'b1;
          rlast_n   = (bus.arlen == 8'd0);
          rstate_n  = R_DATA;
        end
      end
      R_DATA: begin
        if (rvalid_r && bus.rready) begin
          if (rlast_r) begin
            rvalid_n  = 1'b0;
            rlast_n   = 1'b0;
            arready_n = 1'b1;
            rstate_n  = R_IDLE;
          end else begin
            raddr_n = next_addr(raddr, rburst, rsize);
            rcnt_n  = rcnt + 8'd1;
            rdata_n = rbad ? '0 : mem[word_of(raddr_n)];
            rlast_n = (rcnt_n == rlen);
          end
        end
      end
      default: rstate_n = R_IDLE;
    endcase
  end

  // Read-side state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      rstate    <= R_IDLE;
      raddr     <= '0;
      rlen      <= '0;
      rcnt      <= '0;
      rsize     <= '0;
      rburst    <= '0;
      rbad      <= 1'b0;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rlast_r   <= 1'b0;
      rid_r     <= '0;
      rdata_r   <= '0;
      rresp_r   <= '0;
    end else begin
      rstate    <= rstate_n;
      raddr     <= raddr_n;
      rlen      <= rlen_n;
      rcnt      <= rcnt_n;
      rsize     <= rsize_n;
      rburst    <= rburst_n;
      rbad      <= rbad_n;
      arready_r <= arready_n;
      rvalid_r  <= rvalid_n;
      rlast_r   <= rlast_n;
      rid_r     <= rid_n;
      rdata_r   <= rdata_n;
      rresp_r   <= rresp_n;
    end
  end

  assign bus.arready = arready_r;
  assign bus.rvalid  = rvalid_r;
  assign bus.rlast   = rlast_r;
  assign bus.rid     = rid_r;
  assign bus.rdata   = rdata_r;
  assign bus.rresp   = rresp_r;

endmodule
